// File: rtl/matrix_scan_driver.sv
// Scan driver for the 8x8 RGB matrix: double-buffered 8x24 frame store serialised row by
// row into daisy-chained 74HC595s, with one-hot cathode select and tear-free frame swap.
module matrix_scan_driver #(
  parameter int unsigned ClkDiv   = 128,
  parameter int unsigned OnCycles = 8192
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_row_i,
  input  logic [23:0] wr_data_i,
  input  logic        frame_swap_i,
  output logic        frame_done_o,
  output logic        swap_pending_o,
  output logic        ds_o,
  output logic        sh_cp_o,
  output logic        st_cp_o,
  output logic        oe_o,
  output logic        sr_clr_n_o,
  output logic [7:0]  katot_o
);

  localparam int unsigned TW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned OW = $clog2(OnCycles + 1);
  localparam logic [TW-1:0] TLast  = TW'(ClkDiv - 1);
  localparam logic [OW-1:0] OnLast = OW'(OnCycles - 1);

  typedef enum logic [2:0] {StClear, StShift, StLatch, StDisplay, StBlank} state_e;

  state_e        state_q, state_d;
  logic          run_q, run_d;
  logic [2:0]    row_q, row_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          phase_q, phase_d;
  logic [4:0]    bit_q, bit_d;
  logic [OW-1:0] on_q, on_d;
  logic [23:0]   word_q, word_d;
  logic          sel_q, sel_d;
  logic          pend_q, pend_d;
  logic [23:0]   buf_q [2][8];

  logic          ds_q, ds_d;
  logic          sh_q, sh_d;
  logic          st_q, st_d;
  logic          oe_q, oe_d;
  logic          clr_n_q, clr_n_d;
  logic [7:0]    katot_q, katot_d;
  logic          done_q, done_d;

  logic          t_last;
  logic          enter_clear;
  logic          frame_end;
  logic          swap_exec;

  assign t_last = (tcnt_q == TLast);

  // Row sequencing: every timed state counts T-cycle slots; CLEAR and each bit use two slots.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    row_d       = row_q;
    tcnt_d      = tcnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    on_d        = on_q;
    enter_clear = 1'b0;
    frame_end   = 1'b0;

    if (!run_q) begin
      run_d       = 1'b1;
      state_d     = StClear;
      row_d       = 3'd0;
      tcnt_d      = '0;
      phase_d     = 1'b0;
      enter_clear = 1'b1;
    end else begin
      case (state_q)
        StClear: begin
          if (t_last) begin
            tcnt_d = '0;
            if (phase_q) begin
              state_d = StShift;
              phase_d = 1'b0;
              bit_d   = 5'd0;
            end else begin
              phase_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        StShift: begin
          if (t_last) begin
            tcnt_d = '0;
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (bit_q == 5'd23) begin
                state_d = StLatch;
              end else begin
                bit_d = bit_q + 5'd1;
              end
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        StLatch: begin
          if (t_last) begin
            tcnt_d  = '0;
            on_d    = '0;
            state_d = StDisplay;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        StDisplay: begin
          if (on_q == OnLast) begin
            state_d = StBlank;
          end else begin
            on_d = on_q + OW'(1);
          end
        end
        StBlank: begin
          if (t_last) begin
            tcnt_d      = '0;
            state_d     = StClear;
            row_d       = row_q + 3'd1;
            enter_clear = 1'b1;
            frame_end   = (row_q == 3'd7);
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: state_d = StClear;
      endcase
    end
  end

  // Frame publication and row snapshot.
  always_comb begin
    swap_exec = frame_end & pend_q;
    sel_d     = sel_q ^ swap_exec;
    pend_d    = swap_exec ? frame_swap_i : (pend_q | frame_swap_i);
    done_d    = frame_end;
    word_d    = word_q;
    if (enter_clear) begin
      // A write on the swap edge targets the buffer that becomes front on that same edge.
      if (wr_en_i && swap_exec && (wr_row_i == row_d)) begin
        word_d = wr_data_i;
      end else begin
        word_d = buf_q[sel_d][row_d];
      end
    end
  end

  // Output decode from next state so every pin comes straight from a flop.
  always_comb begin
    ds_d    = 1'b0;
    sh_d    = 1'b0;
    st_d    = 1'b0;
    oe_d    = 1'b1;
    clr_n_d = 1'b1;
    katot_d = katot_q;
    case (state_d)
      StClear: begin
        clr_n_d = 1'b0;
        katot_d = 8'h80 >> row_d;
      end
      StShift: begin
        ds_d = word_q[bit_d];
        sh_d = phase_d;
      end
      StLatch:   st_d = 1'b1;
      StDisplay: oe_d = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClear;
      run_q   <= 1'b0;
      row_q   <= 3'd0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= 5'd0;
      on_q    <= '0;
      word_q  <= '0;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      ds_q    <= 1'b0;
      sh_q    <= 1'b0;
      st_q    <= 1'b0;
      oe_q    <= 1'b1;
      clr_n_q <= 1'b0;
      katot_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      row_q   <= row_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      on_q    <= on_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      ds_q    <= ds_d;
      sh_q    <= sh_d;
      st_q    <= st_d;
      oe_q    <= oe_d;
      clr_n_q <= clr_n_d;
      katot_q <= katot_d;
      done_q  <= done_d;
    end
  end

  // Writes always go to the buffer that is back before any toggle on this edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else if (wr_en_i) begin
      buf_q[~sel_q][wr_row_i] <= wr_data_i;
    end
  end

  assign frame_done_o   = done_q;
  assign swap_pending_o = pend_q;
  assign ds_o           = ds_q;
  assign sh_cp_o        = sh_q;
  assign st_cp_o        = st_q;
  assign oe_o           = oe_q;
  assign sr_clr_n_o     = clr_n_q;
  assign katot_o        = katot_q;

endmodule
